// File: rtl/multi_strobe_gen.sv
// Multi-channel programmable strobe generator.
// Each channel emits 1-clock pulses every (T+1) counting edges, where
// T = saturate(cmp << SHIFT). Channels run periodic or one-shot (triggered);
// sync re-aligns all channel phases.
// Optional feature: define MULTI_STROBE_CASCADE_EN to let channel i>0 count
// only on the registered strobe of channel i-1 when casc[i] is set.
module multi_strobe_gen #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CMP_W    = 8,
    parameter int unsigned SHIFT    = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       oneshot,
    input  logic [CHANNELS-1:0]       trig,
    input  logic                      sync,
    input  logic [CHANNELS*CMP_W-1:0] cmp,
    input  logic [CHANNELS-1:0]       casc,
    output logic [CHANNELS-1:0]       strobe,
    output logic [CHANNELS-1:0]       busy
);

    localparam int unsigned FullW = WIDTH + CMP_W;

    typedef enum logic {StIdle, StRun} state_e;

    state_e              state_q [CHANNELS];
    state_e              state_d [CHANNELS];
    logic [WIDTH-1:0]    count_q [CHANNELS];
    logic [WIDTH-1:0]    count_d [CHANNELS];
    logic [CHANNELS-1:0] strobe_q;
    logic [CHANNELS-1:0] strobe_d;
    logic [FullW-1:0]    tc_full [CHANNELS];
    logic [WIDTH-1:0]    term    [CHANNELS];
    logic [CHANNELS-1:0] step_ok;

    // casc is fully consumed only in the cascade build; bit 0 is never used
    logic unused_casc;
    assign unused_casc = ^casc;

    // Terminal count per channel: shifted compare, saturated to the counter range
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            tc_full[i] = FullW'(cmp[i*CMP_W +: CMP_W]) << SHIFT;
            if (|tc_full[i][FullW-1:WIDTH]) begin
                term[i] = '1;
            end else begin
                term[i] = tc_full[i][WIDTH-1:0];
            end
        end
    end

    // Increment condition: cascaded channels step only on the upstream strobe
    always_comb begin
`ifdef MULTI_STROBE_CASCADE_EN
        step_ok = '1;
        for (int i = 1; i < CHANNELS; i++) begin
            step_ok[i] = !casc[i] || strobe_q[i-1];
        end
`else
        step_ok = '1;
`endif
    end

    // Per-channel next state: sync > periodic / one-shot idle / one-shot run
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            count_d[i]  = count_q[i];
            strobe_d[i] = 1'b0;
            state_d[i]  = state_q[i];
            if (sync) begin
                count_d[i] = '0;
            end else if (!oneshot[i]) begin
                state_d[i] = StIdle;
                if (!en[i]) begin
                    count_d[i] = '0;
                end else if (step_ok[i]) begin
                    if (count_q[i] >= term[i]) begin
                        strobe_d[i] = 1'b1;
                        count_d[i]  = '0;
                    end else begin
                        count_d[i] = count_q[i] + WIDTH'(1);
                    end
                end
            end else if (state_q[i] == StIdle) begin
                // Idle holds count at 0; a trigger edge counts from 0
                count_d[i] = '0;
                if (en[i] && trig[i]) begin
                    if (!step_ok[i]) begin
                        state_d[i] = StRun;
                    end else if (term[i] == '0) begin
                        strobe_d[i] = 1'b1;
                    end else begin
                        state_d[i] = StRun;
                        count_d[i] = WIDTH'(1);
                    end
                end
            end else begin
                if (!en[i]) begin
                    state_d[i] = StIdle;
                    count_d[i] = '0;
                end else if (step_ok[i]) begin
                    if (count_q[i] >= term[i]) begin
                        // A trigger on the terminal edge re-arms the shot
                        strobe_d[i] = 1'b1;
                        count_d[i]  = '0;
                        state_d[i]  = trig[i] ? StRun : StIdle;
                    end else begin
                        count_d[i] = trig[i] ? WIDTH'(1) : count_q[i] + WIDTH'(1);
                    end
                end else if (trig[i]) begin
                    count_d[i] = '0;
                end
            end
        end
    end

    // State, counter and strobe registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i] <= '0;
                state_q[i] <= StIdle;
            end
            strobe_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i] <= count_d[i];
                state_q[i] <= state_d[i];
            end
            strobe_q <= strobe_d;
        end
    end

    // Outputs
    always_comb begin
        strobe = strobe_q;
        for (int i = 0; i < CHANNELS; i++) begin
            busy[i] = (state_q[i] == StRun);
        end
    end

endmodule

// File: tb/tb_multi_strobe_gen.sv
// Directed bench for multi_strobe_gen: periodic, T=0, saturation, one-shot,
// sync and cascade select behaviour.
module tb_multi_strobe_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  en, oneshot, trig, casc, strobe, busy;
    logic        sync;
    logic [31:0] cmp;

    logic [0:0]  en_s, oneshot_s, trig_s, casc_s, strobe_s, busy_s;
    logic [7:0]  cmp_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_strobe_gen #(
        .CHANNELS(4), .WIDTH(16), .CMP_W(8), .SHIFT(6)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .oneshot(oneshot), .trig(trig),
        .sync(sync), .cmp(cmp), .casc(casc), .strobe(strobe), .busy(busy)
    );

    multi_strobe_gen #(
        .CHANNELS(1), .WIDTH(8), .CMP_W(8), .SHIFT(6)
    ) dut_sat (
        .clk(clk), .reset(reset), .en(en_s), .oneshot(oneshot_s), .trig(trig_s),
        .sync(sync), .cmp(cmp_s), .casc(casc_s), .strobe(strobe_s), .busy(busy_s)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmp(input int ch, input logic [7:0] v);
        cmp[ch*8 +: 8] = v;
    endtask

    task automatic clear_inputs();
        en = '0; oneshot = '0; trig = '0; casc = '0; sync = 1'b0; cmp = '0;
        en_s = '0; oneshot_s = '0; trig_s = '0; casc_s = '0; cmp_s = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        check_val("rst_strobe", {28'b0, strobe}, 32'h0);
        check_val("rst_busy", {28'b0, busy}, 32'h0);
        check_val("rst_strobe_sat", {31'b0, strobe_s}, 32'h0);

        // Reset wins over enable/trigger with T=0
        en = '1; trig = '1; oneshot = 4'b1010; en_s = 1'b1;
        tick();
        check_val("rst_prio_strobe", {28'b0, strobe}, 32'h0);
        check_val("rst_prio_busy", {28'b0, busy}, 32'h0);
        check_val("rst_prio_sat", {31'b0, strobe_s}, 32'h0);
        do_reset();

        // Periodic, T=64: strobes after edges 64, 129, 194
        en[0] = 1'b1;
        set_cmp(0, 8'd1);
        for (int e = 0; e <= 194; e++) begin
            tick();
            check_val($sformatf("per_e%0d", e), {31'b0, strobe[0]},
                      {31'b0, e == 64 || e == 129 || e == 194});
        end

        // T=0: strobe on every edge, then enable drop
        set_cmp(0, 8'd0);
        for (int e = 0; e < 4; e++) begin
            tick();
            check_val($sformatf("t0_e%0d", e), {31'b0, strobe[0]}, 32'h1);
        end
        en[0] = 1'b0;
        tick();
        check_val("t0_disable", {31'b0, strobe[0]}, 32'h0);
        en[0] = 1'b1;
        set_cmp(0, 8'd1);
        for (int e = 0; e <= 64; e++) begin
            tick();
            check_val($sformatf("reen_e%0d", e), {31'b0, strobe[0]}, {31'b0, e == 64});
        end
        do_reset();

        // Saturation: WIDTH=8, cmp=8 -> T=255, period 256
        en_s = 1'b1;
        cmp_s = 8'd8;
        for (int e = 0; e <= 511; e++) begin
            tick();
            check_val($sformatf("sat_e%0d", e), {31'b0, strobe_s},
                      {31'b0, e == 255 || e == 511});
        end
        do_reset();

        // One-shot: single trigger at edge 10
        oneshot[1] = 1'b1; en[1] = 1'b1; set_cmp(1, 8'd1);
        for (int e = 0; e <= 80; e++) begin
            trig[1] = (e == 10);
            tick();
            check_val($sformatf("os_busy_e%0d", e), {31'b0, busy[1]}, {31'b0, e >= 10 && e < 74});
            check_val($sformatf("os_strb_e%0d", e), {31'b0, strobe[1]}, {31'b0, e == 74});
        end
        // Restart at edge 40 moves the strobe to 104
        for (int e = 0; e <= 110; e++) begin
            trig[1] = (e == 10 || e == 40);
            tick();
            check_val($sformatf("rs_busy_e%0d", e), {31'b0, busy[1]}, {31'b0, e >= 10 && e < 104});
            check_val($sformatf("rs_strb_e%0d", e), {31'b0, strobe[1]}, {31'b0, e == 104});
        end
        // Trigger on the terminal edge re-arms: second strobe 65 edges later
        for (int e = 0; e <= 145; e++) begin
            trig[1] = (e == 10 || e == 74);
            tick();
            check_val($sformatf("ra_busy_e%0d", e), {31'b0, busy[1]}, {31'b0, e >= 10 && e < 139});
            check_val($sformatf("ra_strb_e%0d", e), {31'b0, strobe[1]},
                      {31'b0, e == 74 || e == 139});
        end
        // Enable drop in RUN aborts without a strobe
        for (int e = 0; e <= 30; e++) begin
            trig[1] = (e == 5);
            en[1] = (e != 15);
            tick();
            check_val($sformatf("ab_busy_e%0d", e), {31'b0, busy[1]}, {31'b0, e >= 5 && e < 15});
            check_val($sformatf("ab_strb_e%0d", e), {31'b0, strobe[1]}, 32'h0);
        end
        do_reset();

        // Sync at edge 30: counters realign, busy unaffected
        en[0] = 1'b1; set_cmp(0, 8'd1);
        en[2] = 1'b1; set_cmp(2, 8'd2);
        oneshot[1] = 1'b1; en[1] = 1'b1; set_cmp(1, 8'd1);
        for (int e = 0; e <= 160; e++) begin
            sync = (e == 30);
            trig[1] = (e == 20);
            tick();
            check_val($sformatf("sy_s0_e%0d", e), {31'b0, strobe[0]}, {31'b0, e == 95 || e == 160});
            check_val($sformatf("sy_s2_e%0d", e), {31'b0, strobe[2]}, {31'b0, e == 159});
            check_val($sformatf("sy_s1_e%0d", e), {31'b0, strobe[1]}, {31'b0, e == 95});
            check_val($sformatf("sy_b1_e%0d", e), {31'b0, busy[1]}, {31'b0, e >= 20 && e < 95});
        end
        do_reset();

        // Cascade select: divides ch0 strobe when enabled, ignored otherwise
        en[0] = 1'b1; set_cmp(0, 8'd1);
        en[1] = 1'b1; casc[1] = 1'b1; set_cmp(1, 8'd0);
        for (int e = 0; e <= 130; e++) begin
            tick();
`ifdef MULTI_STROBE_CASCADE_EN
            check_val($sformatf("cas_e%0d", e), {31'b0, strobe[1]}, {31'b0, e == 65 || e == 130});
`else
            check_val($sformatf("cas_e%0d", e), {31'b0, strobe[1]}, 32'h1);
`endif
        end
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
